// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between two requesters:
//   port 0 = core load/store path, port 1 = debug / program-loader port.
//   Round-robin arbitration with a req/gnt/rvalid handshake. Only one access
//   is in flight at a time, and the memory is assumed to return read data a
//   fixed READ_LAT cycles after mem_req.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   req/we/addr/wdata{0,1}     requester access; held until gnt
//   gnt{0,1}                   1-cycle pulse: access issued to memory
//   rvalid{0,1}                1-cycle pulse: rdata holds that port's load
//   rdata                      shared load data, valid only with rvalid0/1
//   busy                       1 while an access is being processed
//   mem_req/mem_we/mem_addr/mem_wdata   memory strobe and command
//   mem_rdata                  memory read data, READ_LAT cycles after mem_req
//
// Every output comes straight from a flop. The ISSUE-cycle command registers
// (mem_we/mem_addr/mem_wdata) double as the latch for the winning request,
// so no separate copy of the request is kept.

module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 2    // legal range 1..4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } acc_t;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    // WAIT counts down from READ_LAT-1; the cycle it reads 0 is the one in
    // which mem_rdata is valid.
    localparam logic [1:0] LAT_INIT = 2'(READ_LAT - 1);

    logic [1:0] state;
    logic [1:0] lat_cnt;
    logic       last;   // port that won the most recent tie
    logic       id;     // port owning the in-flight access
    logic       pick;
    acc_t       sel;

    // On contention the port that did not win last time gets the memory,
    // which makes grants strictly alternate under saturation.
    always_comb begin
        pick = (req0 && req1) ? ~last : req1;
        sel  = pick ? {we1, addr1, wdata1} : {we0, addr0, wdata0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            lat_cnt   <= 2'd0;
            last      <= 1'b1;   // port 0 wins the first tie
            id        <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            // Pulses and strobes default low; address/data hold.
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;

            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        id        <= pick;
                        if (req0 && req1) last <= pick;
                        state     <= ISSUE;
                        busy      <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= sel.we;
                        mem_addr  <= sel.addr;
                        mem_wdata <= sel.wdata;
                        gnt0      <= ~pick;
                        gnt1      <= pick;
                    end
                end
                ISSUE: begin
                    // mem_we still holds the granted request's direction here.
                    if (mem_we) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state   <= WAIT;
                        lat_cnt <= LAT_INIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        rdata   <= mem_rdata;
                        state   <= RESP;
                        rvalid0 <= ~id;
                        rvalid1 <= id;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Three arbiter instances (READ_LAT = 1, 2, 4), each in front of its own
//   behavioural memory. Lane 1 (READ_LAT=2) carries the directed sequences
//   and the random traffic; lanes 0 and 2 carry the latency sweep vectors.
//   The memory returns an address tag for never-written words and drives a
//   poison value outside its single valid read cycle, so a capture on the
//   wrong cycle shows up as bad data.

module tb_dmem_arbiter;

    localparam int NL = 3;

    logic clk;
    logic reset;

    logic        req    [NL][2];
    logic        we     [NL][2];
    logic [31:0] addr   [NL][2];
    logic [31:0] wdata  [NL][2];
    logic        gnt    [NL][2];
    logic        rvalid [NL][2];
    logic [31:0] rdata  [NL];
    logic        busy   [NL];
    logic        mreq   [NL];
    logic        mwe    [NL];
    logic [31:0] maddr  [NL];
    logic [31:0] mwdata [NL];
    logic [31:0] mrdata [NL];

    int total;
    int bad;

    // Unwritten words read back as an address tag; 0x10 reads 0xDEADBEEF.
    function automatic logic [31:0] tag(input logic [31:0] a);
        return 32'hDEADBEFF ^ a;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar k = 0; k < NL; k++) begin : g_lane
        localparam int L = (k == 0) ? 1 : (k == 1) ? 2 : 4;

        bit [31:0] dmem [64];
        bit        dwr  [64];
        bit [31:0] p_addr;
        int        p_cnt;

        dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(L)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req0      (req[k][0]),
            .we0       (we[k][0]),
            .addr0     (addr[k][0]),
            .wdata0    (wdata[k][0]),
            .gnt0      (gnt[k][0]),
            .rvalid0   (rvalid[k][0]),
            .req1      (req[k][1]),
            .we1       (we[k][1]),
            .addr1     (addr[k][1]),
            .wdata1    (wdata[k][1]),
            .gnt1      (gnt[k][1]),
            .rvalid1   (rvalid[k][1]),
            .rdata     (rdata[k]),
            .busy      (busy[k]),
            .mem_req   (mreq[k]),
            .mem_we    (mwe[k]),
            .mem_addr  (maddr[k]),
            .mem_wdata (mwdata[k]),
            .mem_rdata (mrdata[k])
        );

        // Behavioural memory: read data is valid only in the cycle exactly
        // L cycles after the mem_req cycle.
        always @(posedge clk) begin
            if (mreq[k] && mwe[k]) begin
                dmem[maddr[k][7:2]] <= mwdata[k];
                dwr[maddr[k][7:2]]  <= 1'b1;
            end
            if (mreq[k] && !mwe[k]) begin
                p_addr <= maddr[k];
                p_cnt  <= L;
            end else if (p_cnt > 0) begin
                p_cnt <= p_cnt - 1;
            end
        end

        assign mrdata[k] = (p_cnt != 1) ? 32'hA5A5A5A5 :
                           dwr[p_addr[7:2]] ? dmem[p_addr[7:2]] : tag(p_addr);
    end

    // Reference memory: what every load must return, updated at write grant.
    bit [31:0] rmem [NL][64];
    bit        rwr  [NL][64];

    function automatic logic [31:0] ref_rd(input int ln, input logic [31:0] a);
        return rwr[ln][a[7:2]] ? rmem[ln][a[7:2]] : tag(a);
    endfunction

    task automatic ref_wr(input int ln, input logic [31:0] a, input logic [31:0] d);
        rmem[ln][a[7:2]] = d;
        rwr[ln][a[7:2]]  = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int          ln;
        int          p;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        int          rv;    // negedges from request to rvalid (loads)
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [12];

    bit stop;
    bit sat_win;
    int g0, g1;

    // Single access from an idle lane: grant one cycle after sampling, exact
    // rvalid cycle, data, and idle one cycle after completion.
    task automatic run_vec(input vec_t v);
        int          gc;
        int          rc;
        bit          oth;
        logic [31:0] rd;
        gc = 0; rc = 0; oth = 0; rd = '0;
        req[v.ln][v.p]   = 1'b1;
        we[v.ln][v.p]    = v.w;
        addr[v.ln][v.p]  = v.a;
        wdata[v.ln][v.p] = v.d;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (rvalid[v.ln][1-v.p]) oth = 1'b1;
            if (gc == 0 && gnt[v.ln][v.p]) begin
                gc = c;
                req[v.ln][v.p] = 1'b0;
                chk("vec_mem_we", mwe[v.ln], v.w);
                chk("vec_mem_addr", maddr[v.ln], v.a);
                if (v.w) begin
                    chk("vec_mem_wdata", mwdata[v.ln], v.d);
                    ref_wr(v.ln, v.a, v.d);
                end
            end
            if (rc == 0 && rvalid[v.ln][v.p]) begin
                rc = c;
                rd = rdata[v.ln];
            end
            if (gc != 0 && (v.w || rc != 0)) break;
        end
        req[v.ln][v.p] = 1'b0;
        chk("vec_gnt_cycle", gc, 1);
        chk("vec_rvalid_cycle", rc, v.w ? 0 : v.rv);
        if (!v.w) chk("vec_rdata", rd, v.exp);
        chk("vec_other_rvalid", oth, 0);
        @(negedge clk);
        chk("vec_idle_after", busy[v.ln], 0);
    endtask

    // Random requester on lane 1; in saturation mode it re-requests in the
    // same cycle it completes.
    task automatic driver(input int p, input bit gaps);
        while (!stop) begin
            logic        w;
            logic [31:0] a;
            logic [31:0] d;
            logic [31:0] e;
            int          c;
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 15)) << 2;
            d = $urandom;
            req[1][p] = 1'b1; we[1][p] = w; addr[1][p] = a; wdata[1][p] = d;
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (!gnt[1][p] && c < 40);
            req[1][p] = 1'b0;
            if (!gnt[1][p]) begin
                chk("rnd_gnt_timeout", 0, 1);
                break;
            end
            chk("rnd_mem_addr", maddr[1], a);
            chk("rnd_mem_we", mwe[1], w);
            if (w) begin
                chk("rnd_mem_wdata", mwdata[1], d);
                ref_wr(1, a, d);
            end else begin
                e = ref_rd(1, a);
                c = 0;
                do begin
                    @(negedge clk);
                    c++;
                end while (!rvalid[1][p] && c < 10);
                chk("rnd_rvalid_lat", c, 3);
                chk("rnd_rdata", rdata[1], e);
            end
        end
    endtask

    // Protocol invariants on every lane, every cycle.
    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int k = 0; k < NL; k++) begin
                chk("mon_gnt_excl", gnt[k][0] & gnt[k][1], 0);
                chk("mon_rvalid_excl", rvalid[k][0] & rvalid[k][1], 0);
                chk("mon_memreq_is_gnt", mreq[k], gnt[k][0] | gnt[k][1]);
                if (!mreq[k]) chk("mon_we_outside_issue", mwe[k], 0);
            end
            if (sat_win) begin
                if (gnt[1][0]) g0++;
                if (gnt[1][1]) g1++;
            end
        end
    endtask

    initial begin
        int n;
        bit seen;
        bit dirty;
        int diff;

        total = 0; bad = 0; stop = 0; sat_win = 0; g0 = 0; g1 = 0;
        reset = 1'b1;
        for (int k = 0; k < NL; k++)
            for (int p = 0; p < 2; p++) begin
                req[k][p] = 1'b0; we[k][p] = 1'b0;
                addr[k][p] = '0; wdata[k][p] = '0;
            end

        tbl[0]  = '{1, 0, 1'b0, 32'h10, 32'h0,        4, 32'hDEADBEEF};
        tbl[1]  = '{1, 1, 1'b1, 32'h20, 32'h12345678, 0, 32'h0};
        tbl[2]  = '{1, 1, 1'b0, 32'h20, 32'h0,        4, 32'h12345678};
        tbl[3]  = '{0, 0, 1'b0, 32'h10, 32'h0,        3, 32'hDEADBEEF};
        tbl[4]  = '{0, 0, 1'b1, 32'h14, 32'hCAFEF00D, 0, 32'h0};
        tbl[5]  = '{0, 0, 1'b0, 32'h14, 32'h0,        3, 32'hCAFEF00D};
        tbl[6]  = '{0, 1, 1'b0, 32'h18, 32'h0,        3, 32'hDEADBEE7};
        tbl[7]  = '{2, 0, 1'b0, 32'h10, 32'h0,        6, 32'hDEADBEEF};
        tbl[8]  = '{2, 1, 1'b1, 32'h3C, 32'h0BADCAFE, 0, 32'h0};
        tbl[9]  = '{2, 0, 1'b0, 32'h3C, 32'h0,        6, 32'h0BADCAFE};
        tbl[10] = '{2, 0, 1'b0, 32'h04, 32'h0,        6, 32'hDEADBEFB};
        tbl[11] = '{1, 0, 1'b0, 32'h08, 32'h0,        4, 32'hDEADBEF7};

        fork
            monitor();
            begin
                #500000;
                $display("FAIL watchdog actual=timeout expected=finish");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < NL; k++) begin
            chk("rst_flags", {24'h0, gnt[k][0], gnt[k][1], rvalid[k][0], rvalid[k][1],
                              busy[k], mreq[k], mwe[k], 1'b0}, 0);
            chk("rst_mem_addr", maddr[k], 0);
            chk("rst_mem_wdata", mwdata[k], 0);
            chk("rst_rdata", rdata[k], 0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Single accesses and the latency sweep
        for (int i = 0; i < 12; i++) run_vec(tbl[i]);

        // Both ports storing continuously out of reset: 0,1,0,1,...
        reset = 1'b1;
        req[1][0] = 1'b1; we[1][0] = 1'b1; addr[1][0] = 32'h30; wdata[1][0] = 32'h0000AAAA;
        req[1][1] = 1'b1; we[1][1] = 1'b1; addr[1][1] = 32'h34; wdata[1][1] = 32'h0000BBBB;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (gnt[1][0] || gnt[1][1]) begin
                chk("rr_order_port1", gnt[1][1], n % 2);
                n++;
            end
        end
        req[1][0] = 1'b0;
        req[1][1] = 1'b0;
        chk("rr_grant_count", n, 8);
        ref_wr(1, 32'h30, 32'h0000AAAA);
        ref_wr(1, 32'h34, 32'h0000BBBB);
        @(negedge clk);

        // Reset during WAIT of a port 0 load: read is dropped
        req[1][0] = 1'b1; we[1][0] = 1'b0; addr[1][0] = 32'h10;
        @(negedge clk);
        chk("rstmid_gnt0", gnt[1][0], 1);
        req[1][0] = 1'b0;
        @(negedge clk);
        chk("rstmid_busy_in_wait", busy[1], 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_busy", busy[1], 0);
        chk("rstmid_rdata", rdata[1], 0);
        chk("rstmid_mem_req", mreq[1], 0);
        seen = 0; dirty = 0;
        repeat (8) begin
            @(negedge clk);
            if (rvalid[1][0] || rvalid[1][1]) seen = 1;
            if (rdata[1] != 0) dirty = 1;
        end
        chk("rstmid_no_rvalid", seen, 0);
        chk("rstmid_rdata_held", dirty, 0);

        // Random traffic, saturated (fairness window), then with gaps
        sat_win = 1;
        fork
            driver(0, 1'b0);
            driver(1, 1'b0);
            begin
                repeat (300) @(negedge clk);
                sat_win = 0;
                stop = 1;
            end
        join
        diff = (g0 > g1) ? g0 - g1 : g1 - g0;
        chk("fair_diff_le1", diff <= 1, 1);
        chk("fair_both_active", (g0 > 20) && (g1 > 20), 1);

        stop = 0;
        fork
            driver(0, 1'b1);
            driver(1, 1'b1);
            begin
                repeat (300) @(negedge clk);
                stop = 1;
            end
        join
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
